data_mem_lsu: RTL and testbench

- Next-generation MEM-stage data memory for the pipelined core. Replaces the word-only, single-cycle data store.
- Adds byte addressing, byte/half/word loads and stores with sign or zero extension, and misalignment and illegal-operation fault detection.
- Adds a parametrised access latency with a stall handshake to the pipeline.
- With MEM_LAT=0 it matches the old single-cycle timing.

---
 rtl/core_pkg.sv | 42 ++++
 rtl/lsu_load_extend.sv | 26 ++
 rtl/data_mem_lsu.sv | 137 +++++++++++++
 tb/tb_data_mem_lsu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, FSM states,
// the latched request payload and the sub-word store merge.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic            store;
        logic            uns;
        logic [1:0]      size;
        logic [1:0]      offset;
        logic [XLEN-1:0] data;
    } lsu_req_t;

    // Merge store data into the old word; lanes outside the access are kept.
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] old_word,
        input logic [XLEN-1:0] wdata,
        input logic [1:0]      offset,
        input logic [1:0]      size
    );
        logic [XLEN-1:0] r;
        r = old_word;
        case (size)
            SZ_B:    r[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    r[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load lane extraction with sign or zero extension; shared with the cache path.
module lsu_load_extend #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] result
);
    import core_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    result = {{(XLEN-8){~uns & byte_v[7]}}, byte_v};
            SZ_H:    result = {{(XLEN-16){~uns & half_v[15]}}, half_v};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage data memory: byte-addressed sub-word loads/stores, fault detection,
// and a configurable access latency with a pipeline stall handshake.
module data_mem_lsu #(
    parameter int unsigned XLEN       = core_pkg::XLEN,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_ld,
    input  logic            MEM_str,
    input  logic [1:0]      MEM_size,
    input  logic            MEM_unsigned,
    input  logic [XLEN-1:0] MEM_alu_out,
    input  logic [XLEN-1:0] MEM_b2,
    output logic [XLEN-1:0] MEM_data_mem,
    output logic            MEM_stall,
    output logic            MEM_fault
);
    import core_pkg::*;

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = 4;

    logic [XLEN-1:0]       mem [DEPTH];
    state_e                state, state_n;
    lsu_req_t              req_q, cur_req, acc;
    logic [DEPTH_LOG2-1:0] idx, idx_q, acc_idx;
    logic [CW-1:0]         cnt;
    logic                  req, fault_c, accept, we;
    logic [XLEN-1:0]       acc_word, ld_result;

    assign req     = MEM_ld | MEM_str;
    assign idx     = MEM_alu_out[DEPTH_LOG2+1:2];
    assign fault_c = req & ((MEM_size == 2'b11)
                          | ((MEM_size == SZ_H) & MEM_alu_out[0])
                          | ((MEM_size == SZ_W) & (MEM_alu_out[1:0] != 2'b00))
                          | (MEM_ld & MEM_str));

    assign cur_req = '{store: MEM_str, uns: MEM_unsigned, size: MEM_size,
                       offset: MEM_alu_out[1:0], data: MEM_b2};

    // Zero latency works on live inputs; otherwise the latched copy drives the access.
    always_comb begin
        if (MEM_LAT == 0) begin
            acc     = cur_req;
            acc_idx = idx;
        end else begin
            acc     = req_q;
            acc_idx = idx_q;
        end
    end

    assign acc_word = mem[acc_idx];

    lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
        .word   (acc_word),
        .offset (acc.offset),
        .size   (acc.size),
        .uns    (acc.uns),
        .result (ld_result)
    );

    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        we           = 1'b0;
        MEM_stall    = 1'b0;
        MEM_fault    = 1'b0;
        MEM_data_mem = MEM_alu_out;
        if (MEM_LAT == 0) begin
            if (req && !fault_c) begin
                we           = MEM_str;
                MEM_data_mem = MEM_str ? '0 : ld_result;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && !fault_c) begin
                        accept       = 1'b1;
                        MEM_stall    = 1'b1;
                        MEM_data_mem = '0;
                        state_n      = (MEM_LAT == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    MEM_stall    = 1'b1;
                    MEM_data_mem = '0;
                    if (cnt <= CW'(1)) state_n = ST_DONE;
                end
                ST_DONE: begin
                    we           = req_q.store;
                    MEM_data_mem = req_q.store ? '0 : ld_result;
                    state_n      = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
        if (fault_c) begin
            MEM_fault    = 1'b1;
            MEM_stall    = 1'b0;
            MEM_data_mem = '0;
        end
        // Reset aborts any pending store, including one sitting in DONE.
        if (rst) begin
            state_n      = ST_IDLE;
            accept       = 1'b0;
            we           = 1'b0;
            MEM_stall    = 1'b0;
            MEM_fault    = 1'b0;
            MEM_data_mem = MEM_alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            req_q <= '0;
            idx_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_q <= cur_req;
                idx_q <= idx;
                cnt   <= CW'(MEM_LAT - 1);
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[acc_idx] <= store_merge(acc_word, acc.data, acc.offset, acc.size);
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a MEM_LAT=2 instance for the latency/FSM
// behaviour and a MEM_LAT=0 instance for the single-cycle path.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld, str, uns;
    logic [1:0]  size;
    logic [31:0] alu, b2, data;
    logic        stall, fault;
    logic        z_ld, z_str, z_uns;
    logic [1:0]  z_size;
    logic [31:0] z_alu, z_b2, z_data;
    logic        z_stall, z_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] res;
    int          nst;
    logic        exp_st [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    data_mem_lsu #(.XLEN(32), .DEPTH_LOG2(5), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .MEM_ld(ld), .MEM_str(str), .MEM_size(size),
        .MEM_unsigned(uns), .MEM_alu_out(alu), .MEM_b2(b2),
        .MEM_data_mem(data), .MEM_stall(stall), .MEM_fault(fault)
    );

    data_mem_lsu #(.XLEN(32), .DEPTH_LOG2(5), .MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .MEM_ld(z_ld), .MEM_str(z_str), .MEM_size(z_size),
        .MEM_unsigned(z_uns), .MEM_alu_out(z_alu), .MEM_b2(z_b2),
        .MEM_data_mem(z_data), .MEM_stall(z_stall), .MEM_fault(z_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the MEM_LAT=2 instance; returns DONE-cycle data and stall count.
    task automatic op(input logic l, input logic s, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r, output int stalls);
        ld = l; str = s; size = sz; uns = u; alu = a; b2 = d;
        stalls = 0;
        #1;
        while (stall && stalls < 20) begin
            stalls++;
            @(posedge clk); #1;
        end
        r = data;
        @(posedge clk); #1;
        ld = 1'b0; str = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b1; str = 1'b1; size = 2'b10; uns = 1'b0;
        alu = 32'h0000_1234; b2 = '0;
        z_ld = 1'b0; z_str = 1'b0; z_size = 2'b10; z_uns = 1'b0; z_alu = '0; z_b2 = '0;

        @(posedge clk); #1;
        chk("rst_data", data, 32'h0000_1234);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ld = 1'b0; str = 1'b0;
        #1;
        chk("noreq_pass", data, 32'h0000_1234);
        chk("noreq_stall", 32'(stall), 32'd0);

        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, res, nst);
        chk("sw_stalls", 32'(nst), 32'd2);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, '0, res, nst);
        chk("lw_stalls", 32'(nst), 32'd2);
        chk("lw_data", res, 32'hDEAD_BEEF);

        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h1122_3344, res, nst);
        op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFF_FF80, res, nst);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C, '0, res, nst);
        chk("sb_merge", res, 32'h1122_8044);
        op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0D, '0, res, nst);
        chk("lb_signed", res, 32'hFFFF_FF80);
        op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0D, '0, res, nst);
        chk("lbu", res, 32'h0000_0080);

        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_BEEF, res, nst);
        op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0A, '0, res, nst);
        chk("lh_signed", res, 32'hFFFF_BEEF);
        op(1'b1, 1'b0, 2'b01, 1'b1, 32'h08, '0, res, nst);
        chk("lhu_low", res, 32'h0000_BEEF);

        ld = 1'b1; size = 2'b01; alu = 32'h09; #1;
        chk("mis_lh_fault", 32'(fault), 32'd1);
        chk("mis_lh_data", data, 32'd0);
        chk("mis_lh_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ld = 1'b0; #1;
        chk("mis_lh_idle", 32'(stall), 32'd0);
        str = 1'b1; size = 2'b01; alu = 32'h09; b2 = 32'h0000_1111; #1;
        chk("mis_sh_fault", 32'(fault), 32'd1);
        @(posedge clk); #1;
        str = 1'b0; ld = 1'b1; size = 2'b11; alu = 32'h08; #1;
        chk("illegal_size", 32'(fault), 32'd1);
        str = 1'b1; size = 2'b10; #1;
        chk("ld_and_str", 32'(fault), 32'd1);
        @(posedge clk); #1;
        ld = 1'b0; str = 1'b0; #1;
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, '0, res, nst);
        chk("mem_unchanged", res, 32'hBEEF_BEEF);

        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A5_A5A5, res, nst);
        str = 1'b1; size = 2'b10; alu = 32'h04; b2 = 32'h1234_5678; #1;
        chk("rs_t0_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("rs_t1_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("rs_done_stall", 32'(stall), 32'd0);
        rst = 1'b1; #1;
        chk("rs_rst_stall", 32'(stall), 32'd0);
        chk("rs_rst_data", data, 32'h04);
        @(posedge clk); #1;
        rst = 1'b0; str = 1'b0; #1;
        chk("rs_after_stall", 32'(stall), 32'd0);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, '0, res, nst);
        chk("rs_word_kept", res, 32'hA5A5_A5A5);
        chk("rs_idle_stalls", 32'(nst), 32'd2);

        ld = 1'b1; size = 2'b10; uns = 1'b0; alu = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("b2b_stall_%0d", i), 32'(stall), 32'(exp_st[i]));
            chk($sformatf("b2b_data_%0d", i), data, exp_st[i] ? 32'd0 : 32'h1122_8044);
            @(posedge clk);
        end
        #1;
        ld = 1'b0;

        z_alu = 32'h55; #1;
        chk("z_pass", z_data, 32'h55);
        chk("z_pass_stall", 32'(z_stall), 32'd0);
        z_str = 1'b1; z_size = 2'b10; z_alu = 32'h08; z_b2 = 32'hCAFE_F00D; #1;
        chk("z_sw_stall", 32'(z_stall), 32'd0);
        @(posedge clk); #1;
        z_str = 1'b0; z_ld = 1'b1; z_alu = 32'h88; #1;
        chk("z_wrap_lw", z_data, 32'hCAFE_F00D);
        chk("z_lw_stall", 32'(z_stall), 32'd0);
        z_size = 2'b00; z_uns = 1'b1; z_alu = 32'h8B; #1;
        chk("z_lbu", z_data, 32'h0000_00CA);
        z_uns = 1'b0; #1;
        chk("z_lb", z_data, 32'hFFFF_FFCA);
        z_size = 2'b01; z_alu = 32'h8B; #1;
        chk("z_mis_fault", 32'(z_fault), 32'd1);
        chk("z_mis_data", z_data, 32'd0);
        @(posedge clk); #1;
        z_ld = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
